// File: rtl/uart_cmd_bridge.sv
// UART-to-PSRAM command bridge: parses 'R'/'W' frames, issues valid/ready commands and answers over TX.
// Optional build macro UART_CMD_CHECKSUM_EN adds an XOR checksum byte in both directions.
module uart_cmd_bridge #(
   parameter int DELAY_FRAMES = 234,
   parameter int ADDR_WIDTH   = 23,
   parameter int DATA_WIDTH   = 16,
   parameter int IDLE_TIMEOUT = 27000
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  uart_rx,
   output logic                  uart_tx,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic                  cmd_write,
   output logic [ADDR_WIDTH-1:0] cmd_addr,
   output logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic                  rd_valid,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  busy,
   output logic                  err_pulse
);
   localparam int AB    = (ADDR_WIDTH + 7) / 8;
   localparam int DB    = DATA_WIDTH / 8;
   localparam int AW8   = AB * 8;
   localparam int MAXB  = (AB > DB) ? AB : DB;
   localparam int BC_W  = $clog2(MAXB + 1);
   localparam int CNT_W = $clog2(DELAY_FRAMES);
   localparam int TO_W  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
`ifdef UART_CMD_CHECKSUM_EN
   localparam int TXB   = DB + 1;
`else
   localparam int TXB   = DB;
`endif
   localparam int TXW   = TXB * 8;
   localparam int TXC_W = $clog2(TXB + 1);

   localparam logic [7:0] OP_RD = 8'h52, OP_WR = 8'h57, ABORT = 8'h2F;
   localparam logic [7:0] RSP_K = 8'h4B, RSP_E = 8'h45;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {P_OP, P_ADDR, P_DATA, P_ISSUE, P_WAIT_RD
`ifdef UART_CMD_CHECKSUM_EN
      , P_CSUM
`endif
   } p_state_t;
`ifdef UART_CMD_CHECKSUM_EN
   localparam p_state_t P_END = P_CSUM;
`else
   localparam p_state_t P_END = P_ISSUE;
`endif

   // RX synchroniser and bit sampler
   logic             rx_p0, rx_p1;
   rx_state_t        rx_state, rx_next;
   logic [CNT_W-1:0] rx_cnt;
   logic [2:0]       rx_bit;
   logic [7:0]       rx_byte;
   logic             rx_tick, byte_strobe, frame_err;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
      end else begin
         rx_p0 <= uart_rx;
         rx_p1 <= rx_p0;
      end
   end

   assign rx_tick = (rx_state == RX_START) ? (rx_cnt == CNT_W'(DELAY_FRAMES / 2 - 1))
                                           : (rx_cnt == CNT_W'(DELAY_FRAMES - 1));

   always_comb begin
      rx_next     = rx_state;
      byte_strobe = 1'b0;
      frame_err   = 1'b0;
      case (rx_state)
         RX_IDLE:  if (!rx_p1) rx_next = RX_START;
         RX_START: if (rx_tick) rx_next = rx_p1 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
         RX_STOP: if (rx_tick) begin
            rx_next     = RX_IDLE;
            byte_strobe = rx_p1;
            frame_err   = !rx_p1;
         end
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_byte  <= '0;
      end else begin
         rx_state <= rx_next;
         rx_cnt   <= (rx_state == RX_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
         if (rx_state == RX_IDLE) rx_bit <= '0;
         if (rx_state == RX_DATA && rx_tick) begin
            rx_byte <= {rx_p1, rx_byte[7:1]};
            rx_bit  <= rx_bit + 1'b1;
         end
      end
   end

   // Command parser
   p_state_t         p_state, p_next;
   logic [BC_W-1:0]  byte_cnt;
   logic [AW8-1:0]   addr_sh;
   logic [TO_W-1:0]  to_cnt;
   logic             to_hit, in_frame, tx_busy;
   logic             op_ok, op_err, ovr_err, to_err, sum_err;
   logic             take_addr, take_data, q_k, q_e, q_rd;
`ifdef UART_CMD_CHECKSUM_EN
   logic [7:0]       csum;

   function automatic logic [7:0] data_xor(input logic [DATA_WIDTH-1:0] d);
      data_xor = 8'h00;
      for (int i = 0; i < DB; i++) data_xor ^= d[i*8 +: 8];
   endfunction
`endif

   assign in_frame = (p_state != P_OP) && (p_state != P_ISSUE) && (p_state != P_WAIT_RD);
   assign to_hit   = (IDLE_TIMEOUT != 0) && in_frame && (to_cnt == TO_W'(IDLE_TIMEOUT - 1));
   assign cmd_addr = addr_sh[ADDR_WIDTH-1:0];
   assign busy     = (p_state != P_OP) || tx_busy;

   always_comb begin
      p_next    = p_state;
      op_ok     = 1'b0;
      op_err    = 1'b0;
      ovr_err   = 1'b0;
      to_err    = 1'b0;
      sum_err   = 1'b0;
      take_addr = 1'b0;
      take_data = 1'b0;
      q_k       = 1'b0;
      q_e       = 1'b0;
      q_rd      = 1'b0;
      case (p_state)
         P_OP: if (byte_strobe) begin
            if (tx_busy) ovr_err = 1'b1;
            else if (rx_byte == OP_RD || rx_byte == OP_WR) begin
               op_ok  = 1'b1;
               p_next = P_ADDR;
            end else begin
               op_err = 1'b1;
               q_e    = 1'b1;
            end
         end
         P_ISSUE: begin
            ovr_err = byte_strobe;
            if (cmd_valid && cmd_ready) begin
               p_next = cmd_write ? P_OP : P_WAIT_RD;
               q_k    = cmd_write;
            end
         end
         P_WAIT_RD: begin
            ovr_err = byte_strobe;
            if (rd_valid) begin
               q_rd   = 1'b1;
               p_next = P_OP;
            end
         end
         default: begin
            // Frame collection: a bad stop bit, an abort byte or a stall drops the partial frame
            if (frame_err) p_next = P_OP;
            else if (byte_strobe) begin
`ifdef UART_CMD_CHECKSUM_EN
               if (p_state == P_CSUM) begin
                  if (rx_byte == csum) p_next = P_ISSUE;
                  else begin
                     sum_err = 1'b1;
                     q_e     = 1'b1;
                     p_next  = P_OP;
                  end
               end else
`endif
               if (rx_byte == ABORT) p_next = P_OP;
               else if (p_state == P_ADDR) begin
                  take_addr = 1'b1;
                  if (byte_cnt == BC_W'(AB - 1)) p_next = cmd_write ? P_DATA : P_END;
               end else begin
                  take_data = 1'b1;
                  if (byte_cnt == BC_W'(DB - 1)) p_next = P_END;
               end
            end else if (to_hit) begin
               to_err = 1'b1;
               p_next = P_OP;
            end
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         p_state   <= P_OP;
         byte_cnt  <= '0;
         addr_sh   <= '0;
         cmd_wdata <= '0;
         cmd_write <= 1'b0;
         cmd_valid <= 1'b0;
         err_pulse <= 1'b0;
         to_cnt    <= '0;
`ifdef UART_CMD_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         p_state   <= p_next;
         cmd_valid <= (p_next == P_ISSUE);
         err_pulse <= frame_err | op_err | ovr_err | to_err | sum_err;
         to_cnt    <= (byte_strobe || !in_frame || to_hit) ? '0 : to_cnt + 1'b1;
         if (op_ok) begin
            cmd_write <= (rx_byte == OP_WR);
            byte_cnt  <= '0;
         end
         if (take_addr) begin
            addr_sh  <= AW8'({addr_sh, rx_byte});
            byte_cnt <= (byte_cnt == BC_W'(AB - 1)) ? '0 : byte_cnt + 1'b1;
         end
         if (take_data) begin
            cmd_wdata <= DATA_WIDTH'({cmd_wdata, rx_byte});
            byte_cnt  <= (byte_cnt == BC_W'(DB - 1)) ? '0 : byte_cnt + 1'b1;
         end
`ifdef UART_CMD_CHECKSUM_EN
         if (op_ok) csum <= rx_byte;
         else if (take_addr || take_data) csum <= csum ^ rx_byte;
`endif
      end
   end

   // TX response shifter
   tx_state_t        tx_state, tx_next;
   logic [CNT_W-1:0] tx_cnt;
   logic [2:0]       tx_bit;
   logic [7:0]       tx_shift;
   logic [TXW-1:0]   tx_buf;
   logic [TXC_W-1:0] tx_left;
   logic             tx_tick, tx_take, tx_line;

   assign tx_tick = (tx_cnt == CNT_W'(DELAY_FRAMES - 1));
   assign tx_busy = (tx_state != TX_IDLE) || (tx_left != '0);

   always_comb begin
      tx_next = tx_state;
      tx_take = 1'b0;
      tx_line = 1'b1;
      case (tx_state)
         TX_IDLE: if (tx_left != '0) begin
            tx_next = TX_START;
            tx_take = 1'b1;
         end
         TX_START: begin
            tx_line = 1'b0;
            if (tx_tick) tx_next = TX_DATA;
         end
         TX_DATA: begin
            tx_line = tx_shift[0];
            if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
         end
         TX_STOP: if (tx_tick) begin
            tx_next = (tx_left != '0) ? TX_START : TX_IDLE;
            tx_take = (tx_left != '0);
         end
         default: tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_buf   <= '0;
         tx_left  <= '0;
         uart_tx  <= 1'b1;
      end else begin
         tx_state <= tx_next;
         uart_tx  <= tx_line;
         tx_cnt   <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
         if (tx_take) begin
            tx_shift <= tx_buf[TXW-1 -: 8];
            tx_buf   <= tx_buf << 8;
            tx_left  <= tx_left - 1'b1;
            tx_bit   <= '0;
         end else if (tx_state == TX_DATA && tx_tick) begin
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + 1'b1;
         end
         if (q_rd) begin
`ifdef UART_CMD_CHECKSUM_EN
            tx_buf <= {rd_data, data_xor(rd_data)};
`else
            tx_buf <= rd_data;
`endif
            tx_left <= TXC_W'(TXB);
         end else if (q_k || q_e) begin
            tx_buf  <= TXW'(q_k ? RSP_K : RSP_E) << (TXW - 8);
            tx_left <= TXC_W'(1);
         end
      end
   end
endmodule

// File: doc/uart_cmd_bridge.md
Name: uart_cmd_bridge

Overview:
Parametrised UART-to-memory command bridge for the PSRAM path. Receives framed 'R'/'W' commands over UART and issues them to the PSRAM controller through a valid/ready handshake. Returns read data or a write acknowledge over UART TX. Generalises the first-generation UART block with:
- configurable address and data widths;
- a synchronised RX input with start-bit validation and framing-error detection;
- an inter-byte timeout;
- explicit error responses.

Parameters:
DELAY_FRAMES, 234, sys_clk cycles per UART bit (27 MHz / 115200); must be >= 8.
ADDR_WIDTH, 23, command address width; address bytes AB = ceil(ADDR_WIDTH/8).
DATA_WIDTH, 16, data width; must be a multiple of 8; data bytes DB = DATA_WIDTH/8.
IDLE_TIMEOUT, 27000, sys_clk cycles of RX idle inside a partial frame before the parser resets; 0 disables the timeout.

Ports:
sys_clk  in  1  system clock, 27 MHz
sys_rst_n  in  1  asynchronous active-low reset
uart_rx  in  1  UART RX line, asynchronous
uart_tx  out  1  UART TX line
cmd_valid  out  1  command pending to PSRAM controller
cmd_ready  in  1  controller accepts command
cmd_write  out  1  1 = write, 0 = read
cmd_addr  out  ADDR_WIDTH  command address
cmd_wdata  out  DATA_WIDTH  write data
rd_valid  in  1  one-cycle pulse: rd_data valid for the outstanding read
rd_data  in  DATA_WIDTH  read data
busy  out  1  parser not in P_OP or TX not idle
err_pulse  out  1  one-cycle pulse on any error (framing, opcode, overrun, timeout)

Behaviour:
- Clocking: all logic on posedge sys_clk. Async reset drives:
  - uart_tx=1; cmd_valid, cmd_write, err_pulse, busy = 0; cmd_addr, cmd_wdata = 0;
  - all FSMs to idle; byte counters to 0.
- RX input: uart_rx passes through a 2-flop synchroniser, reset value 1.
- RX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - START samples at DELAY_FRAMES/2. If the line is high there, the start bit is a glitch: return to IDLE with no error.
  - DATA takes 8 samples LSB-first, one per DELAY_FRAMES.
  - STOP samples once. Low = framing error: byte discarded, err_pulse, parser reset to P_OP.
  - A good stop sample produces a one-cycle byte_strobe in the same cycle.
- Parser FSM, states P_OP, P_ADDR, P_DATA, P_ISSUE, P_WAIT_RD:
  - P_OP: 0x52 'R' -> P_ADDR (read); 0x57 'W' -> P_ADDR (write). Any other byte -> err_pulse, queue response 0x45 'E', stay in P_OP.
  - P_ADDR: collect AB bytes MSB first. cmd_addr takes the low ADDR_WIDTH bits of the concatenation; excess high bits are ignored. Then go to P_DATA (write) or P_ISSUE (read).
  - P_DATA: collect DB bytes MSB first into cmd_wdata, then go to P_ISSUE.
  - P_ISSUE: cmd_valid=1 the cycle after the last byte_strobe. cmd_addr, cmd_wdata and cmd_write are held stable until cmd_valid && cmd_ready. On accept, cmd_valid=0 next cycle:
    - write -> queue response 0x4B 'K', return to P_OP;
    - read -> P_WAIT_RD.
  - P_WAIT_RD: on rd_valid, latch rd_data into the TX shift buffer, queue DB bytes MSB first, return to P_OP. rd_valid in any other state is ignored.
- Overrun: a byte_strobe in P_ISSUE or P_WAIT_RD, or while TX is non-idle in P_OP, is dropped with err_pulse. The pending command is not disturbed.
- Timeout: in P_ADDR or P_DATA, if IDLE_TIMEOUT cycles elapse with no byte_strobe, return to P_OP with err_pulse. Nothing is transmitted. The counter restarts on every byte_strobe.
- 0x2F '/' byte:
  - in P_ADDR or P_DATA, aborts the frame to P_OP with no error;
  - in P_OP it is not an opcode, so it is treated as invalid (err_pulse, 'E' response).
- TX FSM, states IDLE, START, DATA, STOP:
  - 1 start bit, 8 data bits LSB-first, 1 stop bit, each DELAY_FRAMES cycles.
  - Multi-byte responses are sent back-to-back with no extra idle.
  - TX IDLE holds uart_tx=1.
- Simultaneous events:
  - rd_valid in the same cycle as TX finishing: the new response starts on the next cycle.
  - Reset mid-byte: uart_tx returns high immediately; the partial frame is lost.

Optional Feature:
Macro UART_CMD_CHECKSUM_EN.
- Defined:
  - a P_CSUM state follows the last address/data byte; the received byte must equal the XOR of all preceding frame bytes, opcode included;
  - a mismatch gives err_pulse and an 'E' response, with no command issued;
  - read responses append one XOR byte covering the data bytes.
- Undefined: no checksum byte in either direction; P_CSUM does not exist.

Test Plan:
- Bench uses DELAY_FRAMES=8.
- Write: send 57 01 23 45 BE EF, with cmd_ready tied 1 -> one cmd_valid cycle with cmd_write=1, cmd_addr=0x012345, cmd_wdata=0xBEEF, then TX byte 0x4B.
- Read: send 52 7F FF FF; hold cmd_ready=0 for 5 cycles then 1; pulse rd_valid with rd_data=0xA55A -> cmd_addr=0x7FFFFF stable while stalled, then TX bytes A5, 5A.
- Invalid opcode: byte 0x41 -> err_pulse, TX 0x45, parser in P_OP; a following valid write frame executes normally.
- Framing: byte 0x57 with stop bit forced low -> err_pulse, no command; a 1-sample start glitch (half bit) -> no byte, no error.
- Timeout (IDLE_TIMEOUT=100): send 57 00, then idle 101 cycles -> err_pulse, P_OP; then send 52 00 00 10 -> read issued with addr=0x000010.
- Reset: assert sys_rst_n=0 mid-TX of 0xA5 -> uart_tx=1, cmd_valid=0 immediately; after release, a full write frame completes.
